data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-ported 64-bit byte-addressed data memory.
- Port 0 is the load/store unit; port 1 is the debug/DMA requester.
- Accepts one request at a time, drives the memory control and data signals for exactly one access cycle, then returns a registered response to the granted requester.
- Requests that would run past the end of memory are blocked before the memory is accessed and answered with an error.

Parameters:
- SIZE, 256, memory depth in bytes; must match the depth of the attached data memory.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- p0_req_valid  in  1  port 0 request valid.
- p0_req_ready  out  1  port 0 request accepted this cycle.
- p0_req_write  in  1  port 0 request type: 1 = store, 0 = load.
- p0_req_address  in  64  port 0 byte address.
- p0_req_wdata  in  64  port 0 store data.
- p0_resp_valid  out  1  port 0 response valid.
- p0_resp_ready  in  1  port 0 response consumed.
- p0_resp_rdata  out  64  port 0 load data; 0 for stores and errors.
- p0_resp_error  out  1  port 0 request was out of range.
- p1_*  same set of ports as p0_*, for port 1.
- mem_write  out  1  write strobe to memory.
- mem_read  out  1  read enable to memory.
- mem_address  out  64  byte address to memory.
- mem_wdata  out  64  write data to memory.
- mem_rdata  in  64  read data from memory (combinational).

Behaviour:
- States:
  - IDLE: no transaction outstanding.
  - ACCESS: exactly one cycle driving the memory.
  - RESP: response held until the requester consumes it.
- Reset: state = IDLE and grant = 0. The round-robin pointer is set so that port 0 has priority next.
- Outputs in reset and in IDLE:
  - mem_write, mem_read, all req_ready and all resp_valid are 0.
  - mem_address, mem_wdata, resp_rdata and resp_error are 0.
- Grant is combinational in IDLE.
  - If any request is valid, exactly one req_ready is asserted, for the granted port.
  - The request is latched at the edge where req_valid && req_ready is true.
  - Next state is ACCESS, or RESP directly if the request is out of range.
- Range check: the request is out of range when address > SIZE-8, using a 64-bit unsigned compare. Wrap of address+7 past 2^64 is also an error.
- Error path:
  - No mem_read or mem_write pulse is issued.
  - Next state is RESP with resp_error = 1 and resp_rdata = 0.
- ACCESS cycle:
  - mem_address and mem_wdata come from the latched request.
  - Store: mem_write = 1, mem_read = 0.
  - Load: mem_read = 1, mem_write = 0.
  - At the closing edge, mem_rdata is captured into the response register (loads only) and the state moves to RESP.
- Response is registered: resp_valid is asserted only for the granted port, in every RESP cycle.
  - Both resp_rdata and resp_error stay stable while resp_valid is 1.
  - When resp_valid && resp_ready, the next state is IDLE.
- Latency without backpressure, counted from the accept edge: ACCESS in cycle +1, resp_valid in cycle +2. The next accept is possible in cycle +3.
- Throughput: at most one transaction per 3 cycles.
- req_ready is never asserted outside IDLE; a requester may hold req_valid through ACCESS and RESP.
- A req_valid seen while another transaction is in flight is not lost; it is arbitrated on return to IDLE.
- Reset asserted mid-transaction:
  - The FSM goes to IDLE at that edge and the pending response is discarded.
  - No mem_write is asserted in the cycle following reset.
  - If reset coincides with an ACCESS store, that store still completes in memory, because the memory samples at the same edge.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - When both ports request in IDLE, the port that was not granted last wins.
  - The pointer updates on each accept (not on error-free completion only).
  - A single requester is always granted.
- Undefined: fixed priority; port 0 always wins over port 1. Port 1 can starve under continuous port 0 traffic.

Test Plan:
- Load to an unwritten location: p0 load at address 0x10 (memory initialised to 0x07 per byte) -> accepted in cycle 0, mem_read=1 in cycle 1, p0_resp_valid=1 and p0_resp_rdata=0x0707070707070707 in cycle 2, p0_resp_error=0.
- Store then load: p1 store of 0x1122334455667788 at address 0x20, then p1 load at 0x20 -> mem_write=1 for exactly one cycle; the load returns 0x1122334455667788; byte 0x20 holds 0x88.
- Out-of-range request: p0 load at address 249 with SIZE=256 -> no mem_read/mem_write pulse; resp_valid with resp_error=1 and rdata=0. Address 248 succeeds.
- Contention: p0 and p1 request continuously for 4 transactions -> with ARB_ROUND_ROBIN_EN, grants go p0, p1, p0, p1; without the macro, grants go p0, p0, p0, p0.
- Response backpressure and reset:
  - Hold p0_resp_ready=0 for 5 cycles -> resp_valid and data stay stable and p1_req_ready stays 0; the response completes when resp_ready=1.
  - Assert reset while in RESP -> the next cycle is IDLE with all outputs 0 and no response delivered.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory.
// Optional build macro: ARB_ROUND_ROBIN_EN (round-robin grant; default fixed p0 priority).
//
// Ports:
//   clock, reset            : clock, synchronous active-high reset
//   p0_req_* / p0_resp_*    : load/store unit request and response
//   p1_req_* / p1_resp_*    : debug/DMA request and response
//   mem_write, mem_read     : one-cycle memory strobes
//   mem_address, mem_wdata  : memory address / store data
//   mem_rdata               : combinational memory read data
module data_memory_arbiter #(
    parameter int SIZE = 256
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        p0_req_valid,
    output logic        p0_req_ready,
    input  logic        p0_req_write,
    input  logic [63:0] p0_req_address,
    input  logic [63:0] p0_req_wdata,
    output logic        p0_resp_valid,
    input  logic        p0_resp_ready,
    output logic [63:0] p0_resp_rdata,
    output logic        p0_resp_error,

    input  logic        p1_req_valid,
    output logic        p1_req_ready,
    input  logic        p1_req_write,
    input  logic [63:0] p1_req_address,
    input  logic [63:0] p1_req_wdata,
    output logic        p1_resp_valid,
    input  logic        p1_resp_ready,
    output logic [63:0] p1_resp_rdata,
    output logic        p1_resp_error,

    output logic        mem_write,
    output logic        mem_read,
    output logic [63:0] mem_address,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    // Highest legal start address of an 8-byte access. Any address whose
    // +7 would wrap past 2^64 is far above this, so one compare covers both.
    localparam logic [63:0] LIMIT = 64'(SIZE - 8);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_next;

    logic        grant;
    logic        accept;
    logic        any_valid;
    logic        sel;
    logic        sel_write;
    logic [63:0] sel_address;
    logic [63:0] sel_wdata;
    logic        sel_oor;

    logic        lat_write;
    logic [63:0] lat_address;
    logic [63:0] lat_wdata;
    logic [63:0] resp_rdata;
    logic        resp_error;

    assign any_valid = p0_req_valid | p1_req_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when port 1 should win the next tie.
    logic prio_p1;
    assign sel = p1_req_valid & (~p0_req_valid | prio_p1);
`else
    assign sel = ~p0_req_valid;
`endif

    assign sel_write   = sel ? p1_req_write   : p0_req_write;
    assign sel_address = sel ? p1_req_address : p0_req_address;
    assign sel_wdata   = sel ? p1_req_wdata   : p0_req_wdata;
    assign sel_oor     = sel_address > LIMIT;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        p0_req_ready  = 1'b0;
        p1_req_ready  = 1'b0;
        p0_resp_valid = 1'b0;
        p1_resp_valid = 1'b0;
        p0_resp_rdata = '0;
        p1_resp_rdata = '0;
        p0_resp_error = 1'b0;
        p1_resp_error = 1'b0;
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        mem_address   = '0;
        mem_wdata     = '0;

        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    accept       = 1'b1;
                    p0_req_ready = ~sel;
                    p1_req_ready = sel;
                    state_next   = sel_oor ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                mem_address = lat_address;
                mem_wdata   = lat_wdata;
                mem_write   = lat_write;
                mem_read    = ~lat_write;
                state_next  = RESP;
            end
            RESP: begin
                if (grant) begin
                    p1_resp_valid = 1'b1;
                    p1_resp_rdata = resp_rdata;
                    p1_resp_error = resp_error;
                    if (p1_resp_ready) begin
                        state_next = IDLE;
                    end
                end else begin
                    p0_resp_valid = 1'b1;
                    p0_resp_rdata = resp_rdata;
                    p0_resp_error = resp_error;
                    if (p0_resp_ready) begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            grant       <= 1'b0;
            lat_write   <= 1'b0;
            lat_address <= '0;
            lat_wdata   <= '0;
            resp_rdata  <= '0;
            resp_error  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            prio_p1     <= 1'b0;
`endif
        end else begin
            if (accept) begin
                grant       <= sel;
                lat_write   <= sel_write;
                lat_address <= sel_address;
                lat_wdata   <= sel_wdata;
                // Error responses are formed here; ACCESS is skipped.
                resp_rdata  <= '0;
                resp_error  <= sel_oor;
`ifdef ARB_ROUND_ROBIN_EN
                prio_p1     <= ~sel;
`endif
            end
            if (state == ACCESS) begin
                resp_rdata <= lat_write ? '0 : mem_rdata;
                resp_error <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Scoreboard bench for data_memory_arbiter.
// Byte-array reference model; monitor pops expected responses.
module tb_data_memory_arbiter;

    localparam int SIZE = 256;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        p0_req_valid, p0_req_ready, p0_req_write;
    logic [63:0] p0_req_address, p0_req_wdata;
    logic        p0_resp_valid, p0_resp_ready, p0_resp_error;
    logic [63:0] p0_resp_rdata;
    logic        p1_req_valid, p1_req_ready, p1_req_write;
    logic [63:0] p1_req_address, p1_req_wdata;
    logic        p1_resp_valid, p1_resp_ready, p1_resp_error;
    logic [63:0] p1_resp_rdata;
    logic        mem_write, mem_read;
    logic [63:0] mem_address, mem_wdata, mem_rdata;

    data_memory_arbiter #(.SIZE(SIZE)) dut (
        .clock(clock), .reset(reset),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
        .p0_req_write(p0_req_write), .p0_req_address(p0_req_address),
        .p0_req_wdata(p0_req_wdata), .p0_resp_valid(p0_resp_valid),
        .p0_resp_ready(p0_resp_ready), .p0_resp_rdata(p0_resp_rdata),
        .p0_resp_error(p0_resp_error),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
        .p1_req_write(p1_req_write), .p1_req_address(p1_req_address),
        .p1_req_wdata(p1_req_wdata), .p1_resp_valid(p1_resp_valid),
        .p1_resp_ready(p1_resp_ready), .p1_resp_rdata(p1_resp_rdata),
        .p1_resp_error(p1_resp_error),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Attached data memory (environment).
    logic [7:0] dmem [SIZE];
    logic       mem_init;
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < SIZE; i++) dmem[i] <= 8'h07;
        end else if (mem_write && mem_address <= 64'(SIZE - 8)) begin
            for (int b = 0; b < 8; b++)
                dmem[mem_address[7:0] + 8'(b)] <= mem_wdata[8*b +: 8];
        end
    end
    always_comb begin
        mem_rdata = '0;
        if (mem_address <= 64'(SIZE - 8))
            for (int b = 0; b < 8; b++)
                mem_rdata[8*b +: 8] = dmem[mem_address[7:0] + 8'(b)];
    end

    // Reference model and scoreboard state.
    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    logic [7:0]  rmem [SIZE];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic        glog [$];
    int          checks = 0;
    int          errors = 0;
    logic        busy = 1'b0;
    int          free_from = 0;
    logic        last_grant = 1'b1;
    logic        seen [2] = '{1'b0, 1'b0};
    logic        live = 1'b0;
    int          l_cyc = 0;
    logic        l_w = 1'b0, l_oor = 1'b0;
    logic [63:0] l_a = '0, l_d = '0;

    logic        hold [2] = '{1'b0, 1'b0};
    logic        rw [2];
    logic [63:0] ra [2];
    logic [63:0] rd [2];
    logic        frc [2] = '{1'b0, 1'b0};
    logic        fval [2] = '{1'b1, 1'b1};

    task automatic fail(input string n, input logic [63:0] got, input logic [63:0] want);
        errors++;
        $display("FAIL %s got %h want %h (cycle %0d)", n, got, want, cyc);
    endtask

    task automatic chk_resp(input int p, input logic v, input logic r,
                            input logic [63:0] d, input logic er);
        exp_t e;
        if (!v) return;
        checks++;
        if ((p == 0 ? q0.size() : q1.size()) == 0) begin
            fail($sformatf("p%0d_unexpected_resp", p), {63'd0, v}, 64'd0);
            return;
        end
        e = (p == 0) ? q0[0] : q1[0];
        if (d !== e.rdata || er !== e.err) begin
            fail($sformatf("p%0d_rdata", p), d, e.rdata);
            if (er !== e.err) fail($sformatf("p%0d_error", p), {63'd0, er}, {63'd0, e.err});
        end
        if (!seen[p]) begin
            checks++;
            if (cyc != e.due) fail($sformatf("p%0d_latency", p), 64'(cyc), 64'(e.due));
            seen[p] = 1'b1;
        end
        if (r) begin
            if (p == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
            seen[p]   = 1'b0;
            busy      = 1'b0;
            free_from = cyc + 1;
        end
    endtask

    // Monitor: memory strobes and responses.
    always @(negedge clock) begin
        logic ew, er;
        ew = live && cyc == l_cyc + 1 && !l_oor && l_w;
        er = live && cyc == l_cyc + 1 && !l_oor && !l_w;
        checks++;
        if ({mem_write, mem_read} !== {ew, er})
            fail("mem_strobes", {62'd0, mem_write, mem_read}, {62'd0, ew, er});
        if (ew || er) begin
            checks++;
            if (mem_address !== l_a) fail("mem_address", mem_address, l_a);
            else if (ew && mem_wdata !== l_d) fail("mem_wdata", mem_wdata, l_d);
        end
        chk_resp(0, p0_resp_valid, p0_resp_ready, p0_resp_rdata, p0_resp_error);
        chk_resp(1, p1_resp_valid, p1_resp_ready, p1_resp_rdata, p1_resp_error);
    end

    task automatic accept(input logic win);
        exp_t        e;
        logic [63:0] a;
        a       = ra[win];
        e.err   = a > 64'(SIZE - 8);
        e.rdata = '0;
        e.due   = cyc + (e.err ? 1 : 2);
        if (!e.err) begin
            for (int b = 0; b < 8; b++) begin
                if (rw[win]) rmem[int'(a) + b] = rd[win][8*b +: 8];
                else e.rdata[8*b +: 8] = rmem[int'(a) + b];
            end
        end
        if (win) q1.push_back(e);
        else q0.push_back(e);
        busy       = 1'b1;
        live       = 1'b1;
        l_cyc      = cyc;
        l_w        = rw[win];
        l_oor      = e.err;
        l_a        = a;
        l_d        = rd[win];
        last_grant = win;
        hold[win]  = 1'b0;
        glog.push_back(win);
    endtask

    task automatic drive();
        p0_req_valid   = hold[0];
        p0_req_write   = rw[0];
        p0_req_address = ra[0];
        p0_req_wdata   = rd[0];
        p1_req_valid   = hold[1];
        p1_req_write   = rw[1];
        p1_req_address = ra[1];
        p1_req_wdata   = rd[1];
        p0_resp_ready  = frc[0] ? fval[0] : ($urandom % 4 != 0);
        p1_resp_ready  = frc[1] ? fval[1] : ($urandom % 4 != 0);
    endtask

    task automatic step();
        logic win;
        @(negedge clock);
        #1;
        checks++;
        if (!reset && !busy && cyc >= free_from && (p0_req_valid || p1_req_valid)) begin
            if (p0_req_valid && p1_req_valid) win = RR ? !last_grant : 1'b0;
            else win = p1_req_valid;
            if ({p1_req_ready, p0_req_ready} != (win ? 2'b10 : 2'b01))
                fail("grant", {62'd0, p1_req_ready, p0_req_ready}, win ? 64'd2 : 64'd1);
            accept(win);
        end else if (p0_req_ready || p1_req_ready) begin
            fail("ready_while_busy", {62'd0, p1_req_ready, p0_req_ready}, 64'd0);
        end
        @(posedge clock);
        #1;
        drive();
    endtask

    task automatic set_req(input int p, input logic w, input logic [63:0] a,
                           input logic [63:0] d);
        hold[p] = 1'b1;
        rw[p]   = w;
        ra[p]   = a;
        rd[p]   = d;
    endtask

    task automatic wait_quiet(input int bound);
        int n = 0;
        checks++;
        while ((hold[0] || hold[1] || busy) && n < bound) begin
            step();
            n++;
        end
        if (hold[0] || hold[1] || busy) fail("timeout", 64'(n), 64'(bound));
    endtask

    task automatic do_req(input int p, input logic w, input logic [63:0] a,
                          input logic [63:0] d);
        set_req(p, w, a, d);
        wait_quiet(60);
    endtask

    task automatic check_all_zero(input string n);
        logic [263:0] all;
        all = {p0_req_ready, p1_req_ready, p0_resp_valid, p1_resp_valid,
               mem_write, mem_read, p0_resp_error, p1_resp_error,
               mem_address, mem_wdata, p0_resp_rdata, p1_resp_rdata};
        checks++;
        if (all != '0) fail(n, {56'd0, all[263:256]}, 64'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        case ($urandom % 8)
            0, 1, 2: return 64'($urandom_range(0, 31) * 8);
            3, 4:    return 64'($urandom_range(0, 248));
            5:       return 64'($urandom_range(246, 258));
            6:       return {32'hFFFF_FFFF, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog got 1 want 0");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int bad;
        for (int i = 0; i < SIZE; i++) rmem[i] = 8'h07;
        for (int p = 0; p < 2; p++) begin
            rw[p] = 1'b0;
            ra[p] = '0;
            rd[p] = '0;
        end
        reset    = 1'b1;
        mem_init = 1'b1;
        drive();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset_outputs");
        @(posedge clock);
        #1;
        reset     = 1'b0;
        mem_init  = 1'b0;
        free_from = cyc;

        // Load from untouched memory, store/load round trip.
        do_req(0, 1'b0, 64'h10, 64'h0);
        do_req(1, 1'b1, 64'h20, 64'h1122334455667788);
        checks++;
        if (dmem[32] !== 8'h88) fail("byte_0x20", {56'd0, dmem[32]}, 64'h88);
        do_req(1, 1'b0, 64'h20, 64'h0);

        // Range boundary and address wrap.
        do_req(0, 1'b0, 64'd249, 64'h0);
        do_req(0, 1'b0, 64'd248, 64'h0);
        do_req(0, 1'b1, 64'd248, 64'hDEAD_BEEF_0BAD_F00D);
        do_req(1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h5A5A);
        do_req(1, 1'b0, 64'd248, 64'h0);

        // Response backpressure holds off the other requester.
        frc[0]  = 1'b1;
        fval[0] = 1'b0;
        set_req(0, 1'b0, 64'h18, 64'h0);
        n = 0;
        while (hold[0] && n < 20) begin step(); n++; end
        set_req(1, 1'b0, 64'h28, 64'h0);
        repeat (7) step();
        checks++;
        if (!p0_resp_valid || p1_req_ready)
            fail("backpressure_hold", {62'd0, p0_resp_valid, p1_req_ready}, 64'd2);
        fval[0] = 1'b1;
        wait_quiet(60);
        frc[0] = 1'b0;

        // Reset while a response is held.
        frc[0]  = 1'b1;
        fval[0] = 1'b0;
        set_req(0, 1'b0, 64'h40, 64'h0);
        n = 0;
        while (!seen[0] && n < 20) begin step(); n++; end
        step();
        reset = 1'b1;
        @(negedge clock);
        @(posedge clock);
        #1;
        q0.delete();
        q1.delete();
        busy       = 1'b0;
        live       = 1'b0;
        seen       = '{1'b0, 1'b0};
        hold       = '{1'b0, 1'b0};
        last_grant = 1'b1;
        free_from  = cyc;
        drive();
        @(negedge clock);
        check_all_zero("reset_in_resp");
        @(posedge clock);
        #1;
        reset   = 1'b0;
        fval[0] = 1'b1;
        repeat (4) step();
        frc[0] = 1'b0;

        // Contention with continuous requests from both ports.
        glog.delete();
        frc  = '{1'b1, 1'b1};
        fval = '{1'b1, 1'b1};
        n = 0;
        while (glog.size() < 4 && n < 60) begin
            for (int p = 0; p < 2; p++)
                if (!hold[p]) set_req(p, 1'b0, 64'(p * 64 + 8 * n), 64'h0);
            step();
            n++;
        end
        wait_quiet(60);
        for (int i = 0; i < 4; i++) begin
            logic want;
            want = RR ? 1'(i % 2) : 1'b0;
            checks++;
            if (i >= glog.size()) fail("contention_count", 64'(glog.size()), 64'd4);
            else if (glog[i] !== want)
                fail($sformatf("contention_grant%0d", i), {63'd0, glog[i]}, {63'd0, want});
        end
        frc = '{1'b0, 1'b0};

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < 2; p++)
                if (!hold[p] && $urandom % 3 == 0)
                    set_req(p, 1'($urandom), rand_addr(), {32'($urandom), 32'($urandom)});
            step();
        end
        wait_quiet(200);

        bad = 0;
        for (int i = 0; i < SIZE; i++) if (dmem[i] !== rmem[i]) bad++;
        checks++;
        if (bad != 0) fail("final_memory", 64'(bad), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
